// File: rtl/systolic_ws_engine_pkg.sv
// Shared types, default widths and arithmetic helper for the weight-stationary engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN
    } state_e;

    localparam int DEF_M      = 4;
    localparam int DEF_N      = 4;
    localparam int DEF_A_W    = 8;
    localparam int DEF_B_W    = 8;
    localparam int DEF_C_W    = 32;
    localparam int DEF_KLEN_W = 16;

    // Full-precision signed product; callers truncate to their partial-sum width.
    function automatic logic [63:0] mul_ext(input int a, input int b);
        return 64'(longint'(a) * longint'(b));
    endfunction

endpackage

// File: rtl/systolic_ws_engine_if.sv
// Weight, activation and result streams of the engine, each a valid/ready handshake.
interface systolic_ws_engine_if
    import systolic_pkg::*;
#(
    parameter int M   = DEF_M,
    parameter int N   = DEF_N,
    parameter int A_W = DEF_A_W,
    parameter int B_W = DEF_B_W,
    parameter int C_W = DEF_C_W
);
    logic               w_valid;
    logic               w_ready;
    logic [N*A_W-1:0]   w_data;
    logic               a_valid;
    logic               a_ready;
    logic [M*B_W-1:0]   a_data;
    logic               out_valid;
    logic               out_ready;
    logic [N*C_W-1:0]   out_data;

    modport master (
        output w_valid, w_data, a_valid, a_data, out_ready,
        input  w_ready, a_ready, out_valid, out_data
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, out_ready,
        output w_ready, a_ready, out_valid, out_data
    );
endinterface

// File: rtl/skew_line.sv
// Enable-gated delay line carrying a valid bit alongside the data; DEPTH=0 is a plain wire.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         any_valid_o
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok   = ^{clk, rst, en};
        assign valid_o     = valid_i;
        assign data_o      = data_i;
        assign any_valid_o = 1'b0;
    end else begin : g_shift
        logic [DEPTH-1:0] v_q;
        logic [W-1:0]     d_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
            end else if (en) begin
                v_q[0] <= valid_i;
                for (int k = 1; k < DEPTH; k++) v_q[k] <= v_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                d_q[0] <= data_i;
                for (int k = 1; k < DEPTH; k++) d_q[k] <= d_q[k-1];
            end
        end

        assign valid_o     = v_q[DEPTH-1];
        assign data_o      = d_q[DEPTH-1];
        assign any_valid_o = |v_q;
    end
endmodule

// File: rtl/systolic_ws_engine.sv
// Weight-stationary MxN systolic engine: streamed weight preload, internal skew/deskew,
// control FSM and a single global stall driven by the result handshake.
module systolic_ws_engine
    import systolic_pkg::*;
#(
    parameter int M      = DEF_M,
    parameter int N      = DEF_N,
    parameter int A_W    = DEF_A_W,
    parameter int B_W    = DEF_B_W,
    parameter int C_W    = DEF_C_W,
    parameter int KLEN_W = DEF_KLEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KLEN_W-1:0] k_len,
    output logic              busy,
    output logic              done,
    systolic_ws_engine_if.slave bus
);
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [KLEN_W-1:0] count_q, count_d, klen_q, klen_d;
    logic              w_loaded_q, w_loaded_d;
    logic              w_we, w_ready_c, a_ready_c, a_fire, stall, en, pipe_busy;
    logic              out_valid_q;
    logic [N*C_W-1:0]  out_data_q, out_data_d;

    logic signed [A_W-1:0] w_q      [M][N];
    logic signed [B_W-1:0] act_q    [M][N];
    logic [C_W-1:0]        psum_q   [M][N];
    logic [N-1:0]          v_q      [M];
    logic signed [B_W-1:0] skw_data [M];
    logic [M-1:0]          skw_v, skw_any;
    logic [C_W-1:0]        dsk_data [N];
    logic [N-1:0]          dsk_v, dsk_any;

    assign stall  = out_valid_q && !bus.out_ready;
    assign en     = !stall;
    assign a_fire = bus.a_valid && a_ready_c;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch can be inferred.
        state_d    = state_q;
        row_d      = row_q;
        count_d    = count_q;
        klen_d     = klen_q;
        w_loaded_d = w_loaded_q;
        w_ready_c  = 1'b0;
        a_ready_c  = 1'b0;
        w_we       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.w_valid) begin
                    state_d = LOAD;
                end else if (start && w_loaded_q) begin
                    klen_d  = k_len;
                    count_d = '0;
                    state_d = (k_len == '0) ? DRAIN : COMPUTE;
                end
            end
            LOAD: begin
                w_ready_c = 1'b1;
                if (bus.w_valid) begin
                    w_we = 1'b1;
                    if (row_q == ROW_W'(M - 1)) begin
                        row_d      = '0;
                        w_loaded_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                a_ready_c = !stall;
                if (bus.a_valid && !stall) begin
                    count_d = count_q + 1'b1;
                    if (count_d == klen_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            count_q    <= '0;
            klen_q     <= '0;
            w_loaded_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            count_q    <= count_d;
            klen_q     <= klen_d;
            w_loaded_q <= w_loaded_d;
        end
    end

    // NOTE: weight storage has no reset; w_loaded_q alone decides whether it may be used.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int j = 0; j < N; j++) w_q[row_q][j] <= bus.w_data[j*A_W +: A_W];
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_skew
        skew_line #(.W(B_W), .DEPTH(i)) u_skew (
            .clk, .rst, .en,
            .valid_i     (a_fire),
            .data_i      (bus.a_data[i*B_W +: B_W]),
            .valid_o     (skw_v[i]),
            .data_o      (skw_data[i]),
            .any_valid_o (skw_any[i])
        );
    end

    // Activations move east, partial sums move south; the valid bit rides with the activation.
    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [B_W-1:0] a_in;
            logic [C_W-1:0]        p_in, prod;
            logic                  v_in;

            if (j == 0) begin : g_west
                assign a_in = skw_data[i];
                assign v_in = skw_v[i];
            end else begin : g_inner
                assign a_in = act_q[i][j-1];
                assign v_in = v_q[i][j-1];
            end

            if (i == 0) begin : g_top
                assign p_in = '0;
            end else begin : g_below
                assign p_in = psum_q[i-1][j];
            end

            assign prod = C_W'(mul_ext(int'(a_in), int'(w_q[i][j])));

            always_ff @(posedge clk) begin
                if (rst)     v_q[i][j] <= 1'b0;
                else if (en) v_q[i][j] <= v_in;
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    act_q[i][j]  <= a_in;
                    psum_q[i][j] <= p_in + prod;
                end
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_deskew
        skew_line #(.W(C_W), .DEPTH(N - 1 - j)) u_deskew (
            .clk, .rst, .en,
            .valid_i     (v_q[M-1][j]),
            .data_i      (psum_q[M-1][j]),
            .valid_o     (dsk_v[j]),
            .data_o      (dsk_data[j]),
            .any_valid_o (dsk_any[j])
        );
        assign out_data_d[j*C_W +: C_W] = dsk_data[j];
    end

    always_comb begin
        pipe_busy = out_valid_q || (|skw_any) || (|dsk_any);
        for (int i = 0; i < M; i++) pipe_busy = pipe_busy || (|v_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= &dsk_v;
            if (&dsk_v) out_data_q <= out_data_d;
        end
    end

    assign bus.w_ready   = w_ready_c;
    assign bus.a_ready   = a_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_systolic_ws_engine.sv
// Directed bench: a 2x2 engine driven from a vector table, plus a 4x2 16-bit engine for wrap.
module tb_systolic_ws_engine;

    logic        clk, rst;
    logic        start_a, done_a, busy_a;
    logic [15:0] k_len_a;
    logic        start_b, done_b, busy_b;
    logic [15:0] k_len_b;

    systolic_ws_engine_if #(.M(2), .N(2), .A_W(8), .B_W(8), .C_W(32)) ifa ();
    systolic_ws_engine_if #(.M(4), .N(2), .A_W(8), .B_W(8), .C_W(16)) ifb ();

    systolic_ws_engine #(.M(2), .N(2), .A_W(8), .B_W(8), .C_W(32), .KLEN_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .k_len(k_len_a),
        .busy(busy_a), .done(done_a), .bus(ifa)
    );

    systolic_ws_engine #(.M(4), .N(2), .A_W(8), .B_W(8), .C_W(16), .KLEN_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .k_len(k_len_b),
        .busy(busy_b), .done(done_b), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0]  a0, a1;
        logic signed [31:0] e0, e1;
    } vec_t;

    vec_t tbl [7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_a(input logic [15:0] row0, input logic [15:0] row1);
        int r;
        r = 0;
        for (int t = 0; t < 20 && r < 2; t++) begin
            @(negedge clk);
            ifa.w_valid = 1'b1;
            ifa.w_data  = (r == 0) ? row0 : row1;
            #1;
            if (ifa.w_ready) r++;
        end
        @(negedge clk);
        ifa.w_valid = 1'b0;
        check("a_w_beats", r, 2);
    endtask

    task automatic start_unloaded(input string tag);
        int spur;
        spur = 0;
        @(negedge clk);
        start_a = 1'b1;
        k_len_a = 16'd1;
        @(negedge clk);
        start_a = 1'b0;
        for (int t = 0; t < 5; t++) begin
            #1;
            spur += int'(busy_a) + int'(ifa.out_valid) + int'(done_a);
            @(negedge clk);
        end
        check(tag, spur, 0);
    endtask

    // Runs one pass of n table vectors from index base; vector k offered no earlier than t=k*gap;
    // the first result is held off for stall_len cycles.
    task automatic run_pass(input int base, input int n, input int stall_len, input int gap);
        int t, sent, got, stall_cnt, last_out;
        int acc_t [8];
        bit fin;
        @(negedge clk);
        start_a = 1'b1;
        k_len_a = 16'(n);
        @(negedge clk);
        start_a = 1'b0;
        sent = 0; got = 0; stall_cnt = 0; last_out = -1; fin = 1'b0;
        for (t = 0; t < 200 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            ifa.a_valid = (sent < n) && (t >= sent * gap);
            ifa.a_data  = '0;
            if (ifa.a_valid) ifa.a_data = {tbl[base+sent].a1, tbl[base+sent].a0};
            if (ifa.out_valid && got == 0 && stall_cnt < stall_len) begin
                ifa.out_ready = 1'b0;
                stall_cnt++;
            end else begin
                ifa.out_ready = 1'b1;
            end
            #1;
            if (t == 0) check("busy_in_pass", busy_a, 1);
            if (!ifa.out_ready) begin
                check("stall_hold_c0", ifa.out_data[31:0], tbl[base].e0);
                check("stall_hold_c1", ifa.out_data[63:32], tbl[base].e1);
                check("stall_a_ready", ifa.a_ready, 0);
            end
            if (ifa.a_valid && ifa.a_ready) begin
                acc_t[sent] = t;
                sent++;
            end
            if (ifa.out_valid && ifa.out_ready) begin
                if (got >= n) begin
                    check("extra_output", got + 1, n);
                end else begin
                    check("out_c0", ifa.out_data[31:0], tbl[base+got].e0);
                    check("out_c1", ifa.out_data[63:32], tbl[base+got].e1);
                    if (stall_len == 0) check("latency", t, acc_t[got] + 4);
                end
                got++;
                last_out = t;
            end
            if (done_a) begin
                fin = 1'b1;
                check("outputs_at_done", got, n);
                if (n > 0) check("done_after_last", t, last_out + 1);
                else       check("done_k0", t, 0);
            end
        end
        check("done_seen", fin, 1);
        ifa.a_valid   = 1'b0;
        ifa.out_ready = 1'b1;
    endtask

    initial begin
        int r, sent, got, spur;

        tbl[0] = '{a0:  8'sd5,    a1:  8'sd6,   e0:  32'sd23,  e1:  32'sd34};
        tbl[1] = '{a0:  8'sd1,    a1:  8'sd0,   e0:  32'sd1,   e1:  32'sd2};
        tbl[2] = '{a0:  8'sd0,    a1:  8'sd1,   e0:  32'sd3,   e1:  32'sd4};
        tbl[3] = '{a0: -8'sd1,    a1: -8'sd1,   e0: -32'sd4,   e1: -32'sd6};
        tbl[4] = '{a0: -8'sd128,  a1:  8'sd127, e0:  32'sd253, e1:  32'sd252};
        tbl[5] = '{a0:  8'sd2,    a1: -8'sd3,   e0: -32'sd7,   e1: -32'sd8};
        tbl[6] = '{a0:  8'sd7,    a1:  8'sd9,   e0:  32'sd7,   e1:  32'sd9};

        rst = 1'b1;
        start_a = 1'b0; k_len_a = '0; start_b = 1'b0; k_len_b = '0;
        ifa.w_valid = 1'b0; ifa.w_data = '0; ifa.a_valid = 1'b0; ifa.a_data = '0; ifa.out_ready = 1'b1;
        ifb.w_valid = 1'b0; ifb.w_data = '0; ifb.a_valid = 1'b0; ifb.a_data = '0; ifb.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_w_ready", ifa.w_ready, 0);
        check("rst_a_ready", ifa.a_ready, 0);
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_data", ifa.out_data[31:0] | ifa.out_data[63:32], 0);
        rst = 1'b0;

        start_unloaded("start_without_weights");

        load_a(16'h0201, 16'h0403);
        run_pass(0, 1, 0, 1);
        run_pass(1, 3, 0, 1);
        run_pass(1, 3, 5, 3);
        run_pass(0, 0, 0, 1);
        run_pass(4, 2, 0, 1);

        // Abort a pass mid-COMPUTE with one vector in flight.
        @(negedge clk);
        start_a = 1'b1;
        k_len_a = 16'd3;
        @(negedge clk);
        start_a     = 1'b0;
        ifa.a_valid = 1'b1;
        ifa.a_data  = {8'sd4, 8'sd3};
        @(negedge clk);
        ifa.a_valid = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_out_valid", ifa.out_valid, 0);
        check("abort_out_data", ifa.out_data[31:0] | ifa.out_data[63:32], 0);
        rst  = 1'b0;
        spur = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            #1;
            spur += int'(done_a) + int'(ifa.out_valid) + int'(busy_a);
        end
        check("abort_quiet", spur, 0);
        start_unloaded("start_after_abort");
        load_a(16'h0001, 16'h0100);
        run_pass(6, 1, 0, 1);

        // 16-bit partial sums on a 4-deep array: 4 * (-128 * -128) wraps to 0.
        r = 0;
        for (int t = 0; t < 30 && r < 4; t++) begin
            @(negedge clk);
            ifb.w_valid = 1'b1;
            ifb.w_data  = 16'h8080;
            #1;
            if (ifb.w_ready) r++;
        end
        @(negedge clk);
        ifb.w_valid = 1'b0;
        check("b_w_beats", r, 4);
        @(negedge clk);
        start_b = 1'b1;
        k_len_b = 16'd2;
        @(negedge clk);
        start_b = 1'b0;
        sent = 0;
        got  = 0;
        for (int t = 0; t < 40 && got < 2; t++) begin
            if (t > 0) @(negedge clk);
            ifb.a_valid = (sent < 2);
            ifb.a_data  = (sent == 0) ? 32'h80808080 : 32'h01010101;
            #1;
            if (ifb.a_valid && ifb.a_ready) sent++;
            if (ifb.out_valid) begin
                if (got == 0) check("b_wrap", ifb.out_data, 32'h00000000);
                else          check("b_neg", ifb.out_data, 32'hFE00FE00);
                got++;
            end
        end
        ifb.a_valid = 1'b0;
        check("b_outputs", got, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
